// File: rtl/if_axis_rx_fifo_pkg.sv
// Shared constants for the AXI-Stream receive bridge: register selects,
// STATUS/CONTROL bit positions and the FIFO level-width helper.
package if_axis_pkg;

  // Register selects decoded from addr_i[6:4]
  localparam logic [2:0] REG_STATUS  = 3'b001;
  localparam logic [2:0] REG_DATA    = 3'b010;
  localparam logic [2:0] REG_CONTROL = 3'b011;

  // STATUS bit positions
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_RX_EN     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 16;
  localparam int STAT_LEVEL_W   = 8;

  // CONTROL bit positions
  localparam int CTRL_RX_EN   = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_THR_LSB = 8;
  localparam int CTRL_THR_W   = 8;

  // Level counter must hold 0..depth inclusive
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_axis_rx_fifo_if.sv
// AXI-Stream handshake bundle between a streaming source and the bridge.
interface if_axis_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/if_axis_rx_fifo_axis_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; flush beats push/pop.
module axis_sync_fifo
  import if_axis_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int LW    = level_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             axis_aclk_i,
  input  logic             axis_aresetn_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_level == LW'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign dout_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o & ~flush_i;
  assign w_pop   = pop_i & ~empty_o & ~flush_i;

  // Storage write on accepted push
  // NOTE: the storage array has no reset; its contents are only ever read
  // behind a valid level, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge axis_aclk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  // Pointer and level bookkeeping; flush wins over push/pop
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/if_axis_rx_fifo.sv
// Memory-mapped AXI-Stream receive bridge: buffers stream beats in a FIFO
// and exposes STATUS / DATA (pop-on-read) / CONTROL registers to the CPU.
// Optional feature macro: IF_AXIS_RX_IRQ_EN adds irq_o and a level
// threshold in CONTROL[15:8].
module if_axis_rx_fifo
  import if_axis_pkg::*;
#(
  parameter logic [7:0] SOC_SEGMENT     = 8'hE4,
  parameter logic [7:0] SOC_CLASS       = 8'hA9,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH      = 16
) (
  input  logic        axis_aclk_i,
  input  logic        axis_aresetn_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        data_w_i,
  output logic [31:0] data_o,
  output logic        data_access_o,
  if_axis_rx_fifo_if.slave s_axis
`ifdef IF_AXIS_RX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int LW = level_width(FIFO_DEPTH);

  logic [2:0]                 w_sel;
  logic                       w_rd_access;
  logic                       w_rd_data;
  logic                       w_wr_ctrl;
  logic                       w_flush;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_tready;
  logic [LW-1:0]              w_level;
  logic [31:0]                w_level_ext;
  logic [7:0]                 w_level_sat;
  logic [AXIS_DATA_WIDTH-1:0] w_dout;
  logic [31:0]                w_rd_mux;
  logic                       r_rx_en;
  logic                       r_rd_data_q;
  logic                       w_unused;
`ifdef IF_AXIS_RX_IRQ_EN
  logic [CTRL_THR_W-1:0]      r_thr;
`endif

  assign data_access_o = (addr_i[31:16] == {SOC_SEGMENT, SOC_CLASS});
  assign w_sel         = addr_i[6:4];
  assign w_rd_access   = data_access_o & ~data_w_i;
  assign w_rd_data     = w_rd_access & (w_sel == REG_DATA);
  assign w_wr_ctrl     = data_access_o & data_w_i & (w_sel == REG_CONTROL);
  assign w_flush       = w_wr_ctrl & data_i[CTRL_FLUSH];
  // Pop only on the first cycle of a DATA read, and never from an empty FIFO
  assign w_pop         = w_rd_data & ~r_rd_data_q & ~w_empty;
  // Ready is forced low on a flush cycle so that beat is not taken
  assign w_tready      = r_rx_en & ~w_full & ~w_flush;
  assign s_axis.tready = w_tready;
  assign w_push        = s_axis.tvalid & w_tready;

  assign w_level_ext = 32'(w_level);
  assign w_level_sat = (w_level_ext > 32'd255) ? 8'hFF : w_level_ext[7:0];

`ifdef IF_AXIS_RX_IRQ_EN
  assign w_unused = ^{addr_i[15:7], addr_i[3:0], data_i[31:16], data_i[7:2]};
`else
  assign w_unused = ^{addr_i[15:7], addr_i[3:0], data_i[31:2]};
`endif

  axis_sync_fifo #(
    .WIDTH (AXIS_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .axis_aclk_i    (axis_aclk_i),
    .axis_aresetn_i (axis_aresetn_i),
    .push_i         (w_push),
    .pop_i          (w_pop),
    .flush_i        (w_flush),
    .din_i          (s_axis.tdata),
    .dout_o         (w_dout),
    .full_o         (w_full),
    .empty_o        (w_empty),
    .level_o        (w_level)
  );

  // Read-data mux for the selected register
  // NOTE: the default assignment ahead of the case keeps every path
  // assigned, so no latch is inferred for unmatched selects.
  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      REG_STATUS: begin
        w_rd_mux[STAT_EMPTY]    = w_empty;
        w_rd_mux[STAT_FULL]     = w_full;
        w_rd_mux[STAT_RX_EN]    = r_rx_en;
        w_rd_mux[STAT_OVERFLOW] = 1'b0;
        w_rd_mux[STAT_LEVEL_LSB +: STAT_LEVEL_W] = w_level_sat;
      end
      REG_DATA: begin
        if (!w_empty) w_rd_mux = 32'(w_dout);
      end
      REG_CONTROL: begin
        w_rd_mux[CTRL_RX_EN] = r_rx_en;
`ifdef IF_AXIS_RX_IRQ_EN
        w_rd_mux[CTRL_THR_LSB +: CTRL_THR_W] = r_thr;
`endif
      end
      default: w_rd_mux = '0;
    endcase
  end

  // Registered read data, updated on every read access and held otherwise
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i)  data_o <= '0;
    else if (w_rd_access) data_o <= w_rd_mux;
  end

  // Previous-cycle DATA-read flag for pop edge detection
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) r_rd_data_q <= 1'b0;
    else                 r_rd_data_q <= w_rd_data;
  end

  // CONTROL register writes
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      r_rx_en <= 1'b0;
`ifdef IF_AXIS_RX_IRQ_EN
      r_thr   <= 8'd1;
`endif
    end else if (w_wr_ctrl) begin
      r_rx_en <= data_i[CTRL_RX_EN];
`ifdef IF_AXIS_RX_IRQ_EN
      r_thr   <= data_i[CTRL_THR_LSB +: CTRL_THR_W];
`endif
    end
  end

`ifdef IF_AXIS_RX_IRQ_EN
  // Level-threshold interrupt, re-evaluated every cycle
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) irq_o <= 1'b0;
    else irq_o <= r_rx_en & (w_level_ext >= 32'(r_thr)) & (r_thr != '0);
  end
`endif

endmodule
